// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data RAM arbiter between MEM-stage core port and debug/loader port
// Core has priority; a starvation counter bounds the debug wait, reads return one cycle after grant.
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  input  logic [2:0]    core_ubhw,
  output logic          core_stall,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic [2:0]    ram_ubhw,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CORE_RD = 2'd1,
    DBG_RD  = 2'd2
  } own_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [2:0] UBHW_WORD  = 3'b010;

  own_e       state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       pick_dbg, pick_core;

  assign pick_dbg   = dbg_req & (~core_req | (starve_q == STARVE_LIM));
  assign pick_core  = core_req & ~pick_dbg;
  assign core_stall = core_req & pick_dbg;
  assign dbg_gnt    = pick_dbg;

  // RAM port mux; unused fields are driven to zero so an idle bus carries no X.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    ram_ubhw  = 3'b000;
    if (pick_core) begin
      ram_addr  = core_addr;
      ram_wdata = core_wdata;
      ram_we    = core_we & rst;
      ram_ubhw  = core_ubhw;
    end else if (pick_dbg) begin
      ram_addr  = dbg_addr;
      ram_wdata = dbg_wdata;
      ram_we    = dbg_we & rst;
      ram_ubhw  = UBHW_WORD;
    end
  end

  // Counter cannot pass the limit: at the limit a pending dbg request wins instead.
  always_comb begin
    starve_d = starve_q;
    if (!dbg_req || pick_dbg) begin
      starve_d = 4'd0;
    end else if (pick_core && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    state_d     = IDLE;
    core_rvalid = 1'b0;
    core_rdata  = '0;
    dbg_rvalid  = 1'b0;
    dbg_rdata   = '0;
    if (pick_core && !core_we) begin
      state_d = CORE_RD;
    end else if (pick_dbg && !dbg_we) begin
      state_d = DBG_RD;
    end
    case (state_q)
      CORE_RD: begin
        core_rvalid = 1'b1;
        core_rdata  = ram_rdata;
      end
      DBG_RD: begin
        dbg_rvalid = 1'b1;
        dbg_rdata  = ram_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic [2:0]  core_ubhw;
  logic        core_stall, core_rvalid;
  logic [31:0] core_rdata;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic [31:0] ram_addr, ram_wdata;
  logic        ram_we;
  logic [2:0]  ram_ubhw;
  logic [31:0] ram_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_ubhw  (core_ubhw),
    .core_stall (core_stall),
    .core_rvalid(core_rvalid),
    .core_rdata (core_rdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_ubhw   (ram_ubhw),
    .ram_rdata  (ram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; core_ubhw = 3'b000;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    ram_rdata = 32'h0;
    tick();
    tick();
    // reset state: no requests, every output zero
    chk("rst_core_stall", core_stall, 0);
    chk("rst_core_rvalid", core_rvalid, 0);
    chk("rst_core_rdata", core_rdata, 0);
    chk("rst_dbg_gnt", dbg_gnt, 0);
    chk("rst_dbg_rvalid", dbg_rvalid, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_ubhw", ram_ubhw, 0);
    rst = 1'b1;
    tick();

    // core-only load
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10; core_ubhw = 3'b010;
    #1;
    chk("ld_ram_we", ram_we, 0);
    chk("ld_core_stall", core_stall, 0);
    chk("ld_ram_addr", ram_addr, 32'h10);
    tick();
    core_req = 1'b0;
    ram_rdata = 32'hDEADBEEF;
    #1;
    chk("ld_core_rvalid", core_rvalid, 1);
    chk("ld_core_rdata", core_rdata, 32'hDEADBEEF);
    chk("ld_dbg_rvalid", dbg_rvalid, 0);
    tick();
    chk("ld_idle_rdata", core_rdata, 0);

    // dbg write with core idle
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'h12345678;
    #1;
    chk("dw_gnt", dbg_gnt, 1);
    chk("dw_ram_we", ram_we, 1);
    chk("dw_ram_ubhw", ram_ubhw, 3'b010);
    chk("dw_ram_addr", ram_addr, 32'h20);
    chk("dw_ram_wdata", ram_wdata, 32'h12345678);
    tick();
    dbg_req = 1'b0; dbg_we = 1'b0;
    #1;
    chk("dw_core_rvalid", core_rvalid, 0);
    chk("dw_dbg_rvalid", dbg_rvalid, 0);
    chk("dw_dbg_rdata", dbg_rdata, 0);
    tick();

    // both requesting reads continuously: 4 core grants then 1 dbg grant, repeating
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h80;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h84;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("st_gnt_%0d", i), dbg_gnt, (i % 5) == 4);
      chk($sformatf("st_stall_%0d", i), core_stall, (i % 5) == 4);
      if (i > 0) begin
        chk($sformatf("st_crv_%0d", i), core_rvalid, ((i - 1) % 5) != 4);
        chk($sformatf("st_drv_%0d", i), dbg_rvalid, ((i - 1) % 5) == 4);
      end
      tick();
    end
    core_req = 1'b0; dbg_req = 1'b0;
    tick();

    // alternating core read 0x40 then dbg read 0x44
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40; core_ubhw = 3'b000;
    #1;
    chk("alt_ram_addr_c", ram_addr, 32'h40);
    chk("alt_ram_ubhw_c", ram_ubhw, 3'b000);
    tick();
    core_req = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h44;
    ram_rdata = 32'hAAAA0040;
    #1;
    chk("alt_core_rvalid", core_rvalid, 1);
    chk("alt_core_rdata", core_rdata, 32'hAAAA0040);
    chk("alt_dbg_gnt", dbg_gnt, 1);
    chk("alt_ram_addr_d", ram_addr, 32'h44);
    chk("alt_ram_ubhw_d", ram_ubhw, 3'b010);
    tick();
    dbg_req = 1'b0;
    ram_rdata = 32'hBBBB0044;
    #1;
    chk("alt_dbg_rvalid", dbg_rvalid, 1);
    chk("alt_dbg_rdata", dbg_rdata, 32'hBBBB0044);
    chk("alt_core_rvalid2", core_rvalid, 0);
    tick();

    // build starve_cnt to 3, then reset mid-access
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h60;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h64;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("pre_gnt_%0d", i), dbg_gnt, 0);
      tick();
    end
    rst = 1'b0;
    core_we = 1'b1;
    ram_rdata = 32'hCAFEF00D;
    #1;
    chk("rs_ram_we", ram_we, 0);
    chk("rs_core_stall", core_stall, 0);
    chk("rs_core_rvalid_before", core_rvalid, 1);
    tick();
    rst = 1'b1;
    core_we = 1'b0;
    #1;
    chk("rs_core_rvalid", core_rvalid, 0);
    chk("rs_core_rdata", core_rdata, 0);
    chk("rs_dbg_rvalid", dbg_rvalid, 0);
    // starve_cnt cleared by reset: dbg must wait the full 4 core grants again
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("post_gnt_%0d", i), dbg_gnt, i == 4);
      tick();
    end
    core_req = 1'b0; dbg_req = 1'b0;
    tick();

    // core stores for 20 cycles with dbg idle
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h70; core_wdata = 32'h0F0F0F0F; core_ubhw = 3'b010;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("wr_stall_%0d", i), core_stall, 0);
      chk($sformatf("wr_ram_we_%0d", i), ram_we, 1);
      tick();
    end
    chk("wr_core_rvalid", core_rvalid, 0);
    // dbg arrives after the stores: counter started from 0, so 4 core grants first
    core_we = 1'b0;
    dbg_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("wr_post_gnt_%0d", i), dbg_gnt, i == 4);
      tick();
    end
    core_req = 1'b0; dbg_req = 1'b0;
    tick();
    tick();
    chk("end_core_rvalid", core_rvalid, 0);
    chk("end_dbg_rvalid", dbg_rvalid, 0);
    chk("end_ram_we", ram_we, 0);
    chk("end_ram_wdata", ram_wdata, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
